instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Encodes one-hot op selects plus operand fields into 16-bit instruction words.
- Buffers the words in a small FIFO and streams them, each with a sequential write address, to the instruction-memory write port.
- Sits between the test/program loader and instruction memory; it produces the format that the decode stage consumes.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- ADDR_W, 8, width of the instruction-memory write address.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous FIFO clear; the address counter is kept.
- addr_load  in  1  loads the write-address counter from addr_in.
- addr_in  in  ADDR_W  start address.
- in_valid  in  1  input op valid.
- in_ready  out  1  encoder can accept.
- op_onehot  in  16  bit k set selects opcode k; bit0 = NOP.
- rd  in  4  destination register.
- rs1  in  4  source register 1.
- rs2  in  4  source register 2, or 4-bit immediate.
- offset  in  12  branch offset.
- out_valid  out  1  out_instr is valid.
- out_ready  in  1  memory accepts the word.
- out_instr  out  16  encoded word.
- out_addr  out  ADDR_W  write address for out_instr.
- err_pulse  out  1  one-cycle flag for an illegal op_onehot.
- err_count  out  8  illegal-op count; saturates at 255.
- occupancy  out  $clog2(DEPTH)+1  FIFO fill level.

Behaviour:
- Opcode map (op_onehot bit -> out_instr[15:12]):
  - 0 NOP, 1 ADD, 2 SUB, 3 MUL, 4 LD, 5 ST, 6 CMP, 7 MOV
  - 8 OR, 9 AND, A NOT, B LSL, C UBRANCH, D LSR, E BEQ, F BGT
- Field packing:
  - Branch ops (C, E, F): [11:0] = offset.
  - All other ops: [11:8] = rd, [7:4] = rs1, [3:0] = rs2.
  - NOP: word is 16'h0000.
- Legality: op_onehot must have exactly one bit set. Zero bits or more than one bit is illegal.
- Accept rule: transfer occurs when in_valid && in_ready.
  - in_ready = !full && !flush.
  - A push while full is refused even if a pop happens in the same cycle.
- Illegal accepted op:
  - Completes the handshake but is not pushed.
  - err_pulse goes high the following cycle for one cycle.
  - err_count increments, saturating at 255.
- Legal accepted op: pushed into the FIFO. out_valid rises the next cycle if the FIFO was empty (1-cycle latency).
- Output:
  - out_instr and out_addr come from the FIFO head and are stable while out_valid && !out_ready.
  - A pop occurs on out_valid && out_ready.
  - Each pop increments the address counter, which wraps from 2^ADDR_W-1 to 0.
- Push and pop in the same cycle (FIFO neither empty nor full): occupancy is unchanged.
- flush:
  - Next cycle: occupancy = 0 and out_valid = 0.
  - Pointers reset; err_count and the address counter are kept.
  - Takes priority over push and pop in the same cycle, so no pop is counted.
- addr_load:
  - Next cycle: address counter = addr_in.
  - If a pop coincides, the load wins and the popped word uses the old address.
- Reset (asynchronous, mid-transfer included):
  - out_valid = 0, out_instr = 0, out_addr = 0.
  - in_ready = 1 on the first edge after reset is released.
  - err_pulse = 0, err_count = 0, occupancy = 0.
  - FIFO pointers are cleared.
- FIFO storage is registered: head read through a pointer mux, no combinational path from in_* to out_*.

Decomposition:
- Shared package isa_pkg holds:
  - the 4-bit opcode localparams (ADD_OP ... BGT_OP, NOP_OP = 0);
  - field bit positions (OPC_MSB/LSB, RD, RS1, RS2, OFFSET);
  - an is_branch_op constant list.
- The decode stage uses the same package.
- One sub-module: instr_fifo (parameterised DEPTH x 16-bit synchronous FIFO with flush, full, empty and count). Encoding logic and the address counter stay in the top level.

Test Plan:
- Reset, then push op_onehot=16'h0002, rd=3, rs1=1, rs2=2 with out_ready=1 -> next cycle out_instr=16'h1312, out_addr=0, out_valid=1 for one cycle.
- addr_load with addr_in=8'hFE, then push BEQ (16'h4000, offset=12'h05A) and MOV (16'h0080, rd=4, rs1=7) -> 16'hE05A@FE, then 16'h747x@FF; a third word lands at 00 (wrap).
- Hold out_ready=0 and push 5 legal ops with DEPTH=4 -> in_ready drops after 4 and occupancy=4; with out_ready=1, words drain in order and in_ready returns.
- Push op_onehot=16'h0000, then 16'h0006 -> no out_valid, two err_pulse cycles, err_count=2; then 256 more illegal ops -> err_count stays 255.
- FIFO holding 3 entries; assert flush together with in_valid and out_ready -> in_ready=0 that cycle, no pop, occupancy=0 next cycle, out_addr unchanged.
- Assert reset while out_valid=1 and out_ready=0 -> all outputs at reset values immediately; after release, a new push emits at out_addr=0.

Source files
------------

// File: rtl/isa_pkg.sv
`default_nettype none
// ============================================================================
// isa_pkg : opcode values and field positions of the 16-bit instruction word
// Rev 1.0
// ============================================================================
package isa_pkg;

  localparam int INSTR_W = 16;

  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [3:0]         opcode_t;

  localparam opcode_t NOP_OP     = 4'h0;
  localparam opcode_t ADD_OP     = 4'h1;
  localparam opcode_t SUB_OP     = 4'h2;
  localparam opcode_t MUL_OP     = 4'h3;
  localparam opcode_t LD_OP      = 4'h4;
  localparam opcode_t ST_OP      = 4'h5;
  localparam opcode_t CMP_OP     = 4'h6;
  localparam opcode_t MOV_OP     = 4'h7;
  localparam opcode_t OR_OP      = 4'h8;
  localparam opcode_t AND_OP     = 4'h9;
  localparam opcode_t NOT_OP     = 4'hA;
  localparam opcode_t LSL_OP     = 4'hB;
  localparam opcode_t UBRANCH_OP = 4'hC;
  localparam opcode_t LSR_OP     = 4'hD;
  localparam opcode_t BEQ_OP     = 4'hE;
  localparam opcode_t BGT_OP     = 4'hF;

  localparam int OPC_MSB    = 15;
  localparam int OPC_LSB    = 12;
  localparam int RD_MSB     = 11;
  localparam int RD_LSB     = 8;
  localparam int RS1_MSB    = 7;
  localparam int RS1_LSB    = 4;
  localparam int RS2_MSB    = 3;
  localparam int RS2_LSB    = 0;
  localparam int OFFSET_MSB = 11;
  localparam int OFFSET_LSB = 0;

  // One bit per opcode value; set bits carry a 12-bit offset instead of registers.
  localparam logic [15:0] BRANCH_OP_MASK = (16'h0001 << UBRANCH_OP)
                                         | (16'h0001 << BEQ_OP)
                                         | (16'h0001 << BGT_OP);

  function automatic logic is_branch_op(input opcode_t opc);
    return BRANCH_OP_MASK[opc];
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fifo.sv
`default_nettype none
// ============================================================================
// instr_fifo : DEPTH x WIDTH synchronous FIFO with flush, full, empty, count
// Rev 1.0
// ============================================================================
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] c_ptr_one = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   c_cnt_one = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   c_depth   = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign full    = (r_count == c_depth);
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign rd_data = r_mem[r_rd_ptr];

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// instr_encoder : one-hot op + operands -> 16-bit words streamed to imem
// Rev 1.0
// ============================================================================
module instr_encoder
  import isa_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    addr_load,
  input  logic [ADDR_W-1:0]       addr_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [15:0]             op_onehot,
  input  logic [3:0]              rd,
  input  logic [3:0]              rs1,
  input  logic [3:0]              rs2,
  input  logic [11:0]             offset,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             out_instr,
  output logic [ADDR_W-1:0]       out_addr,
  output logic                    err_pulse,
  output logic [7:0]              err_count,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam logic [ADDR_W-1:0] c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};

  opcode_t          w_opc;
  instr_t           w_word;
  instr_t           w_head;
  logic             w_legal;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             r_err_pulse;
  logic [7:0]       r_err_count;
  logic [ADDR_W-1:0] r_addr;

  assign w_legal = (op_onehot != '0) && ((op_onehot & (op_onehot - 16'd1)) == '0);

  always_comb begin
    w_opc = NOP_OP;
    for (int k = 0; k < 16; k++) begin
      if (op_onehot[k]) w_opc = opcode_t'(k);
    end
  end

  always_comb begin
    w_word = '0;
    if (w_opc == NOP_OP) begin
      w_word = '0;
    end else if (is_branch_op(w_opc)) begin
      w_word[OPC_MSB:OPC_LSB]       = w_opc;
      w_word[OFFSET_MSB:OFFSET_LSB] = offset;
    end else begin
      w_word[OPC_MSB:OPC_LSB] = w_opc;
      w_word[RD_MSB:RD_LSB]   = rd;
      w_word[RS1_MSB:RS1_LSB] = rs1;
      w_word[RS2_MSB:RS2_LSB] = rs2;
    end
  end

  assign in_ready = !w_full && !flush;
  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept && w_legal;
  assign w_pop    = out_valid && out_ready && !flush;

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .push    (w_push),
    .pop     (w_pop),
    .wr_data (w_word),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (occupancy)
  );

  // Head is masked while empty so stale storage never shows on the port.
  assign out_valid = !w_empty;
  assign out_instr = w_empty ? '0 : w_head;
  assign out_addr  = r_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr <= '0;
    end else if (addr_load) begin
      r_addr <= addr_in;
    end else if (w_pop) begin
      r_addr <= r_addr + c_addr_one;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err_pulse <= w_accept && !w_legal;
      if (w_accept && !w_legal && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// tb_instr_encoder : directed and random stimulus against a queue-based model
// Rev 1.0
// ============================================================================
module tb_instr_encoder;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 8;
  localparam int OCC_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              addr_load;
  logic [ADDR_W-1:0] addr_in;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       op_onehot;
  logic [3:0]        rd;
  logic [3:0]        rs1;
  logic [3:0]        rs2;
  logic [11:0]       offset;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              err_pulse;
  logic [7:0]        err_count;
  logic [OCC_W-1:0]  occupancy;

  always #5 clk = ~clk;

  instr_encoder #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .addr_load (addr_load),
    .addr_in   (addr_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_onehot (op_onehot),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .offset    (offset),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .occupancy (occupancy)
  );

  int tests = 0;
  int fails = 0;

  logic [15:0]       m_q[$];
  logic [ADDR_W-1:0] m_addr;
  logic [7:0]        m_errcnt;
  logic              m_errp;
  logic [ADDR_W-1:0] saved_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word built straight from the opcode table: NOP is zero, branches carry offset.
  function automatic logic [15:0] ref_word(input logic [15:0] op, input logic [3:0] d,
                                           input logic [3:0] s1, input logic [3:0] s2,
                                           input logic [11:0] off);
    int          k;
    logic [3:0]  opc;
    k   = $clog2(op);
    opc = 4'(k);
    if (k == 0) return 16'h0000;
    if (k == 12 || k == 14 || k == 15) return {opc, off};
    return {opc, d, s1, s2};
  endfunction

  function automatic logic [15:0] rand_onehot();
    logic [15:0] one;
    one = 16'h0001;
    return one << $urandom_range(0, 15);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_addr   = '0;
    m_errcnt = '0;
    m_errp   = 1'b0;
  endtask

  // Called just after an active edge with inputs already applied.
  task automatic cycle();
    logic ready, acc, legal, pop;
    #1;
    ready = (m_q.size() < DEPTH) && !flush;
    check("in_ready",  32'(in_ready),  32'(ready));
    check("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
    check("out_instr", 32'(out_instr), (m_q.size() > 0) ? 32'(m_q[0]) : 32'h0);
    check("out_addr",  32'(out_addr),  32'(m_addr));
    check("occupancy", 32'(occupancy), 32'(m_q.size()));
    check("err_pulse", 32'(err_pulse), 32'(m_errp));
    check("err_count", 32'(err_count), 32'(m_errcnt));
    acc   = in_valid && ready;
    legal = ($countones(op_onehot) == 1);
    pop   = (m_q.size() > 0) && out_ready && !flush;
    m_errp = acc && !legal;
    if (acc && !legal && m_errcnt != 8'hFF) m_errcnt = m_errcnt + 8'd1;
    if (flush) begin
      m_q.delete();
    end else begin
      if (pop) void'(m_q.pop_front());
      if (acc && legal) m_q.push_back(ref_word(op_onehot, rd, rs1, rs2, offset));
    end
    if (addr_load) m_addr = addr_in;
    else if (pop)  m_addr = m_addr + 8'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [15:0] op);
    in_valid  = 1'b1;
    op_onehot = op;
    rd        = 4'($urandom);
    rs1       = 4'($urandom);
    rs2       = 4'($urandom);
    offset    = 12'($urandom);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; addr_load = 1'b0; addr_in = '0;
    in_valid = 1'b0; op_onehot = '0; rd = '0; rs1 = '0; rs2 = '0; offset = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_instr", 32'(out_instr), 32'h0);
    check("rst_out_addr",  32'(out_addr),  32'h0);
    check("rst_occupancy", 32'(occupancy), 32'h0);
    check("rst_err_count", 32'(err_count), 32'h0);
    check("rst_in_ready",  32'(in_ready),  32'h1);
    cycle();

    // ADD r3, r1, r2 with the sink ready
    set_op(16'h0002); rd = 4'd3; rs1 = 4'd1; rs2 = 4'd2; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("add_word",  32'(out_instr), 32'h1312);
    check("add_addr",  32'(out_addr),  32'h00);
    check("add_valid", 32'(out_valid), 32'h1);
    cycle();
    check("add_gone",  32'(out_valid), 32'h0);

    // Address load near the top, then wrap
    out_ready = 1'b0; addr_load = 1'b1; addr_in = 8'hFE;
    cycle();
    addr_load = 1'b0;
    set_op(16'h4000); offset = 12'h05A;
    cycle();
    set_op(16'h0080); rd = 4'd4; rs1 = 4'd7;
    cycle();
    set_op(16'h0002);
    cycle();
    in_valid = 1'b0;
    check("beq_word", 32'(out_instr), 32'hE05A);
    check("beq_addr", 32'(out_addr),  32'hFE);
    out_ready = 1'b1;
    cycle();
    check("mov_word", 32'(out_instr[15:4]), 32'h747);
    check("mov_addr", 32'(out_addr),        32'hFF);
    cycle();
    check("wrap_addr", 32'(out_addr), 32'h00);
    cycle();

    // Fill beyond DEPTH with the sink stalled, then drain
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_op(rand_onehot());
      cycle();
    end
    in_valid = 1'b0;
    check("full_occ",   32'(occupancy), 32'(DEPTH));
    check("full_ready", 32'(in_ready),  32'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    check("drain_ready", 32'(in_ready), 32'h1);

    // Illegal ops
    set_op(16'h0000);
    cycle();
    check("illegal0_pulse", 32'(err_pulse), 32'h1);
    set_op(16'h0006);
    cycle();
    in_valid = 1'b0;
    check("illegal1_pulse", 32'(err_pulse), 32'h1);
    cycle();
    check("illegal_count", 32'(err_count), 32'h2);
    check("illegal_pulse_drop", 32'(err_pulse), 32'h0);
    for (int i = 0; i < 256; i++) begin
      set_op(16'(($urandom_range(0, 1) == 0) ? 16'h0000 : 16'hC003));
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    check("illegal_sat", 32'(err_count), 32'hFF);

    // Flush with push and pop requested in the same cycle
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_op(rand_onehot());
      cycle();
    end
    saved_addr = m_addr;
    set_op(rand_onehot()); flush = 1'b1; out_ready = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_occ",   32'(occupancy), 32'h0);
    check("flush_valid", 32'(out_valid), 32'h0);
    check("flush_addr",  32'(out_addr),  32'(saved_addr));
    cycle();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 8) set_op(rand_onehot());
      else set_op(16'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      addr_load = ($urandom_range(0, 29) == 0);
      addr_in   = 8'($urandom);
      cycle();
    end
    flush = 1'b0; addr_load = 1'b0; in_valid = 1'b0;

    // Asynchronous reset while a word is stalled at the output
    out_ready = 1'b0;
    set_op(16'h0004);
    cycle();
    set_op(16'h0010);
    cycle();
    in_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 32'h1);
    reset = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'h0);
    check("arst_out_instr", 32'(out_instr), 32'h0);
    check("arst_out_addr",  32'(out_addr),  32'h0);
    check("arst_occupancy", 32'(occupancy), 32'h0);
    check("arst_err_count", 32'(err_count), 32'h0);
    check("arst_err_pulse", 32'(err_pulse), 32'h0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    set_op(16'h0002);
    cycle();
    in_valid = 1'b0;
    check("post_rst_valid", 32'(out_valid), 32'h1);
    check("post_rst_addr",  32'(out_addr),  32'h0);
    out_ready = 1'b1;
    cycle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
